// File: rtl/serial_frame_rx_pkg.sv
// Shared definitions for the serial frame link: receiver FSM states and parity modes.
// Reused by the matching transmitter.
package serial_frame_rx_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } rx_state_t;

    localparam int unsigned PAR_EVEN = 0;
    localparam int unsigned PAR_ODD  = 1;

    // sum is the XOR of all data bits and the parity bit
    function automatic logic parity_good(input logic sum, input int unsigned mode);
        return sum == ((mode == PAR_ODD) ? 1'b1 : 1'b0);
    endfunction

endpackage

// File: rtl/serial_frame_rx_bit_sync.sv
// Two-flop synchroniser for a single asynchronous input; idles high after reset.
module bit_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/serial_frame_rx.sv
// Asynchronous serial frame receiver (8N1/8E1 style) with mid-bit sampling, parity/stop
// checking and a one-entry valid/ready output buffer.
module serial_frame_rx
    import serial_frame_rx_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 868,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned PARITY_EN  = 1,
    parameter int unsigned PARITY_ODD = PAR_EVEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rxd,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun_err,
    output logic              busy
);

    localparam int unsigned   TW     = $clog2(CLK_DIV);
    localparam int unsigned   CW     = $clog2(DATA_W + 1);
    localparam logic [TW-1:0] T_MID  = TW'(CLK_DIV / 2);
    localparam logic [TW-1:0] T_LAST = TW'(CLK_DIV - 1);
    localparam logic [CW-1:0] C_LAST = CW'(DATA_W - 1);

    rx_state_t         state, state_nx;
    logic              rxd_s;
    logic [TW-1:0]     timer;
    logic [CW-1:0]     bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic              par_ok;
    logic              commit;
    logic              tick;
    logic              stop_ok;
    logic              stop_bad;

    bit_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (rxd_s)
    );

    assign tick = (timer == T_MID);

    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (!rxd_s) state_nx = S_START;
            S_START:  if (tick) state_nx = rxd_s ? S_IDLE : S_DATA;
            S_DATA:   if (tick && bit_cnt == C_LAST)
                          state_nx = (PARITY_EN != 0) ? S_PARITY : S_STOP;
            S_PARITY: if (tick) state_nx = S_STOP;
            S_STOP:   if (tick) state_nx = rxd_s ? S_IDLE : S_BREAK;
            S_BREAK:  if (rxd_s) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != S_IDLE);
        stop_ok  = (state == S_STOP) && tick && rxd_s;
        stop_bad = (state == S_STOP) && tick && !rxd_s;
    end

    // Timer is never reloaded at the start mid-point: it started on the start edge, so
    // free-running from there lands every later T_MID in the middle of its bit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            timer   <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            par_ok  <= 1'b1;
            commit  <= 1'b0;
        end else begin
            commit <= stop_ok;
            if (state == S_IDLE || state == S_BREAK || timer == T_LAST) timer <= '0;
            else                                                         timer <= timer + 1'b1;
            case (state)
                S_IDLE: begin
                    bit_cnt <= '0;
                    par_ok  <= 1'b1;
                end
                S_DATA: if (tick) begin
                    shreg   <= {rxd_s, shreg[DATA_W-1:1]};
                    bit_cnt <= bit_cnt + 1'b1;
                end
                S_PARITY: if (tick) par_ok <= parity_good(^shreg ^ rxd_s, PARITY_ODD);
                default: ;
            endcase
        end
    end

    // A commit in the same cycle as an accept refills the buffer rather than clearing it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_data    <= '0;
            out_valid   <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            parity_err  <= 1'b0;
            overrun_err <= 1'b0;
            frame_err   <= stop_bad;
            if (out_valid && out_ready) out_valid <= 1'b0;
            if (commit) begin
                if (!par_ok) begin
                    parity_err <= 1'b1;
                end else if (!out_valid || out_ready) begin
                    out_data  <= shreg;
                    out_valid <= 1'b1;
                end else begin
                    overrun_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Self-checking bench for serial_frame_rx: directed cases plus random frames against a
// frame-level model, on a 16-clock and a 5-clock bit period instance.
module tb_serial_frame_rx;

    localparam int unsigned DIV_A = 16;
    localparam int unsigned DIV_B = 5;
    localparam int unsigned P_ODD = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       rxd_a, rxd_b, ready_a, ready_b;
    logic [7:0] data_a, data_b;
    logic       valid_a, pe_a, fe_a, oe_a, busy_a;
    logic       valid_b, pe_b, fe_b, oe_b, busy_b;

    serial_frame_rx #(.CLK_DIV(DIV_A), .DATA_W(8), .PARITY_EN(1), .PARITY_ODD(P_ODD)) dut_a (
        .clk(clk), .rst(rst), .rxd(rxd_a), .out_data(data_a), .out_valid(valid_a),
        .out_ready(ready_a), .parity_err(pe_a), .frame_err(fe_a), .overrun_err(oe_a),
        .busy(busy_a)
    );

    serial_frame_rx #(.CLK_DIV(DIV_B), .DATA_W(8), .PARITY_EN(1), .PARITY_ODD(P_ODD)) dut_b (
        .clk(clk), .rst(rst), .rxd(rxd_b), .out_data(data_b), .out_valid(valid_b),
        .out_ready(ready_b), .parity_err(pe_b), .frame_err(fe_b), .overrun_err(oe_b),
        .busy(busy_b)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] acc_a[$];
    logic [7:0] acc_b[$];
    int pe_na = 0, fe_na = 0, oe_na = 0;
    int pe_nb = 0, fe_nb = 0, oe_nb = 0;
    int b_acc, b_pe, b_fe, b_oe;

    // Observed activity, accumulated; the stimulus side only reads deltas.
    always @(negedge clk) begin
        if (valid_a && ready_a) acc_a.push_back(data_a);
        if (valid_b && ready_b) acc_b.push_back(data_b);
        pe_na = pe_na + int'(pe_a);
        fe_na = fe_na + int'(fe_a);
        oe_na = oe_na + int'(oe_a);
        pe_nb = pe_nb + int'(pe_b);
        fe_nb = fe_nb + int'(fe_b);
        oe_nb = oe_nb + int'(oe_b);
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic snap(input bit w);
        b_acc = w ? acc_b.size() : acc_a.size();
        b_pe  = w ? pe_nb : pe_na;
        b_fe  = w ? fe_nb : fe_na;
        b_oe  = w ? oe_nb : oe_na;
    endtask

    task automatic expect_deltas(input string tag, input int n_exp, input logic [7:0] d_exp,
                                 input int pe_e, input int fe_e, input int oe_e, input bit w);
        int n;
        logic [7:0] got;
        n   = (w ? acc_b.size() : acc_a.size()) - b_acc;
        got = 8'h00;
        if (n > 0) got = w ? acc_b[b_acc] : acc_a[b_acc];
        check({tag, ".bytes"}, 16'(n), 16'(n_exp));
        if (n_exp > 0) check({tag, ".data"}, {8'h00, got}, {8'h00, d_exp});
        check({tag, ".parity_err"}, 16'((w ? pe_nb : pe_na) - b_pe), 16'(pe_e));
        check({tag, ".frame_err"}, 16'((w ? fe_nb : fe_na) - b_fe), 16'(fe_e));
        check({tag, ".overrun_err"}, 16'((w ? oe_nb : oe_na) - b_oe), 16'(oe_e));
        check({tag, ".busy_idle"}, {15'h0, (w ? busy_b : busy_a)}, 16'h0);
    endtask

    task automatic drive(input logic b, input int n, input bit w);
        if (w) rxd_b = b;
        else   rxd_a = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input logic par, input logic stop, input int hold,
                        input bit w, output logic busy_seen);
        int div;
        div = w ? DIV_B : DIV_A;
        drive(1'b0, div, w);
        for (int i = 0; i < 8; i++) drive(d[i], div, w);
        drive(par, div, w);
        if (stop) drive(1'b1, div, w);
        else      drive(1'b0, div + hold, w);
        busy_seen = w ? busy_b : busy_a;
        if (w) rxd_b = 1'b1;
        else   rxd_a = 1'b1;
    endtask

    // Frame-level model: a stop bit of 0 is a framing error; otherwise the ones count of
    // data plus parity bit must match the parity mode, else parity error; else one byte.
    task automatic frame(input string tag, input logic [7:0] d, input logic par,
                         input logic stop, input int hold, input bit w);
        logic bs;
        int   ones;
        bit   pe;
        snap(w);
        send(d, par, stop, hold, w, bs);
        if (!stop) check({tag, ".busy_held_low"}, {15'h0, bs}, 16'h1);
        repeat ((w ? DIV_B : DIV_A) + 6) @(negedge clk);
        ones = $countones(d) + int'(par);
        pe   = stop && ((ones % 2) != int'(P_ODD));
        expect_deltas(tag, (stop && !pe) ? 1 : 0, d, int'(pe), int'(!stop), 0, w);
    endtask

    initial begin
        logic       bs;
        logic [7:0] d;
        logic       par, stop;

        rst = 1'b0; rxd_a = 1'b1; rxd_b = 1'b1; ready_a = 1'b1; ready_b = 1'b1;
        repeat (3) @(negedge clk);
        check("rst.valid", {15'h0, valid_a}, 16'h0);
        check("rst.data", {8'h0, data_a}, 16'h0);
        check("rst.errs", {13'h0, pe_a, fe_a, oe_a}, 16'h0);
        check("rst.busy", {15'h0, busy_a}, 16'h0);
        check("rst.b_valid_busy", {14'h0, valid_b, busy_b}, 16'h0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        frame("t1", 8'hA5, 1'b0, 1'b1, 0, 1'b0);
        frame("t2", 8'h3C, 1'b1, 1'b1, 0, 1'b0);
        frame("t3", 8'h55, 1'b0, 1'b0, 40, 1'b0);

        snap(1'b0);
        drive(1'b0, 5, 1'b0);
        drive(1'b1, 40, 1'b0);
        expect_deltas("t4", 0, 8'h00, 0, 0, 0, 1'b0);

        ready_a = 1'b0;
        snap(1'b0);
        send(8'h11, 1'b0, 1'b1, 0, 1'b0, bs);
        send(8'h22, 1'b0, 1'b1, 0, 1'b0, bs);
        repeat (DIV_A + 6) @(negedge clk);
        expect_deltas("t5", 0, 8'h00, 0, 0, 1, 1'b0);
        check("t5.valid_held", {15'h0, valid_a}, 16'h1);
        check("t5.data_held", {8'h0, data_a}, 16'h0011);
        snap(1'b0);
        ready_a = 1'b1;
        repeat (3) @(negedge clk);
        expect_deltas("t5.accept", 1, 8'h11, 0, 0, 0, 1'b0);
        check("t5.valid_drop", {15'h0, valid_a}, 16'h0);

        ready_a = 1'b0;
        send(8'h5A, 1'b0, 1'b1, 0, 1'b0, bs);
        repeat (DIV_A + 6) @(negedge clk);
        check("t6.pre_valid", {15'h0, valid_a}, 16'h1);
        check("t6.pre_data", {8'h0, data_a}, 16'h005A);
        drive(1'b0, DIV_A, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b1, DIV_A, 1'b0);
        drive(1'b1, DIV_A / 2, 1'b0);
        check("t6.busy_mid", {15'h0, busy_a}, 16'h1);
        rst = 1'b0;
        @(negedge clk);
        check("t6.rst_outs", {valid_a, pe_a, fe_a, oe_a, busy_a, 3'h0, data_a}, 16'h0);
        rst = 1'b1;
        ready_a = 1'b1;
        repeat (12 * DIV_A) @(negedge clk);
        frame("t6.after", 8'h81, 1'b0, 1'b1, 0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            d    = 8'($urandom);
            par  = (^d) ^ ($urandom_range(0, 3) == 0);
            stop = ($urandom_range(0, 5) != 0);
            frame($sformatf("rnd%0d", i), d, par, stop, int'($urandom_range(5, 40)), 1'b0);
        end

        frame("div5.t1", 8'hA5, 1'b0, 1'b1, 0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            d    = 8'($urandom);
            par  = (^d) ^ ($urandom_range(0, 3) == 0);
            stop = ($urandom_range(0, 5) != 0);
            frame($sformatf("div5.rnd%0d", i), d, par, stop, int'($urandom_range(5, 20)), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
